// File: rtl/feature_pkg.sv
// Shared widths, entry layout and FSM encoding for the feature collector.
package feature_pkg;

  localparam int X_W        = 10;
  localparam int Y_W        = 10;
  localparam int SCORE_W    = 8;
  localparam int COS_W      = 12;
  localparam int SIN_W      = 12;
  localparam int PAYLOAD_W  = X_W + Y_W + SCORE_W + COS_W + SIN_W;  // 52
  localparam int ENTRY_W    = PAYLOAD_W + 1;                        // 53
  localparam int MARKER_BIT = PAYLOAD_W;                            // 52

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_TERM   = 2'd2
  } state_t;

  // Feature entry: marker clear, X in the MSBs down to sin in the LSBs.
  function automatic logic [ENTRY_W-1:0] pack_feature(
    input logic [X_W-1:0]     x,
    input logic [Y_W-1:0]     y,
    input logic [SCORE_W-1:0] score,
    input logic [COS_W-1:0]   cos_v,
    input logic [SIN_W-1:0]   sin_v
  );
    return {1'b0, x, y, score, cos_v, sin_v};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty/count status.
module sync_fifo #(
  parameter int WIDTH = 53,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses the push even if a pop frees a slot this cycle.
  assign do_push = i_push && (count != DEPTH_C);
  assign do_pop  = i_pop  && (count != '0);

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write port.
  // NOTE: the array has no reset; empty/valid comes from count, so contents never matter while unread.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_data;
  end

  assign o_data  = mem[rd_ptr];
  assign o_full  = (count == DEPTH_C);
  assign o_empty = (count == '0);
  assign o_count = count;

endmodule

// File: rtl/feature_collector.sv
// Collects detector keypoints of one frame into a FIFO and closes each
// completed frame with a marker entry carrying the accepted-feature count.
module feature_collector
  import feature_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_end,
  input  logic                 i_flag,
  input  logic [X_W-1:0]       i_coordinate_X,
  input  logic [Y_W-1:0]       i_coordinate_Y,
  input  logic [SCORE_W-1:0]   i_score,
  input  logic [COS_W-1:0]     i_cos,
  input  logic [SIN_W-1:0]     i_sin,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [ENTRY_W-1:0]   o_data,
  output logic                 o_last,
  output logic [CNT_W-1:0]     o_frame_count,
  output logic [7:0]           o_drop_count,
  output logic                 o_busy
);

  localparam int FAW = $clog2(DEPTH);
  localparam logic [FAW:0] DEPTH_C = (FAW + 1)'(DEPTH);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [7:0]           drop_q;
  logic [CNT_W-1:0]     frame_cnt_q;

  logic                 push;
  logic [ENTRY_W-1:0]   push_data;
  logic [ENTRY_W-1:0]   marker;
  logic                 accept;
  logic                 drop;
  logic                 marker_done;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FAW:0]         fifo_count;

  // Marker entry: flag bit set, frame count in the low bits, zeros between.
  always_comb begin
    marker             = '0;
    marker[CNT_W-1:0]  = cnt_q;
    marker[MARKER_BIT] = 1'b1;
  end

  // Next-state and push decisions; i_start outranks everything in the cycle.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d     = state_q;
    push        = 1'b0;
    push_data   = pack_feature(i_coordinate_X, i_coordinate_Y, i_score, i_cos, i_sin);
    accept      = 1'b0;
    drop        = 1'b0;
    marker_done = 1'b0;
    if (i_start) begin
      state_d = ST_ACTIVE;
    end else begin
      case (state_q)
        ST_ACTIVE: begin
          if (i_flag) begin
            if (!fifo_full) begin
              push   = 1'b1;
              accept = 1'b1;
            end else begin
              drop = 1'b1;
            end
          end
          if (i_end) state_d = ST_TERM;
        end
        ST_TERM: begin
          if (!fifo_full) begin
            push        = 1'b1;
            push_data   = marker;
            marker_done = 1'b1;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register and per-frame counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      drop_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (i_start) begin
        cnt_q  <= '0;
        drop_q <= '0;
      end else begin
        if (accept && (cnt_q != '1))   cnt_q  <= cnt_q + 1'b1;
        if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 1'b1;
        if (marker_done)               frame_cnt_q <= cnt_q;
      end
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_data  (push_data),
    .i_pop   (i_ready),
    .o_data  (o_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  // The full flag and the occupancy count must always agree.
  always_comb begin
    assert (i_rst || (fifo_full == (fifo_count == DEPTH_C)));
  end

  assign o_valid       = !fifo_empty;
  assign o_last        = o_data[MARKER_BIT];
  assign o_frame_count = frame_cnt_q;
  assign o_drop_count  = drop_q;
  assign o_busy        = (state_q != ST_IDLE);

endmodule
